data_store_writer: RTL

Write-side counterpart of the data-space read mux in the ATmega32A emulator. Accepts byte store requests from the CPU (ST/STS/OUT/PUSH), buffers up to two in a posted-write queue, decodes each address into exactly one destination and issues a single-cycle write strobe to that destination. Destinations are the GP register file (0x0000-0x001F), the IO file (0x0020-0x005F, or direct IO addressing), or SRAM (0x0060 and above). A hazard output lets the read path stall while a matching store is still pending.

---
 rtl/dmem_pkg.sv | 65 ++++++
 rtl/data_store_writer_fifo.sv | 70 +++++++
 rtl/data_store_writer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared data-memory definitions for the ATmega32A data space:
//               region boundaries, store-queue entry layout, destination
//               target encoding and the address decode function that both
//               the read mux and the store writer use.
//               Optional feature macro: STORE_BOUNDS_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  localparam logic [15:0] REG_TOP  = 16'h001F;
  localparam logic [15:0] IO_TOP   = 16'h005F;
  localparam logic [15:0] SRAM_TOP = 16'h085F;
  localparam logic [15:0] IO_BASE  = 16'h0020;

  typedef enum logic [1:0] {
    TGT_REG  = 2'd0,
    TGT_IO   = 2'd1,
    TGT_SRAM = 2'd2,
    TGT_NONE = 2'd3
  } dmem_tgt_e;

  // One posted store: address (or IO index), byte and IO-only qualifier
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        io_only;
  } store_entry_t;

  // Physical destination: which file and the index inside it
  typedef struct packed {
    dmem_tgt_e   tgt;
    logic [10:0] idx;
  } dmem_target_t;

  // Normalise a data-space address or IO index to a physical target.
  // IO index N and data address N+0x20 produce identical results.
  function automatic dmem_target_t dmem_decode(input logic [15:0] addr,
                                               input logic        io_only);
    dmem_target_t t;
    t.tgt = TGT_SRAM;
    t.idx = addr[10:0];
    if (io_only) begin
      t.tgt = TGT_IO;
      t.idx = {5'd0, addr[5:0]};
    end else if (addr <= REG_TOP) begin
      t.tgt = TGT_REG;
      t.idx = {6'd0, addr[4:0]};
    end else if (addr <= IO_TOP) begin
      t.tgt = TGT_IO;
      t.idx = {5'd0, addr[5:0] - IO_BASE[5:0]};
    end
`ifdef STORE_BOUNDS_CHECK_EN
    else if (addr > SRAM_TOP) begin
      t.tgt = TGT_NONE;
      t.idx = 11'd0;
    end
`endif
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_store_writer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : store_fifo
// Description : DEPTH-entry circular buffer of posted stores. Exposes the
//               head entry for issue and every slot (address, qualifier and
//               valid flag) for read-after-write hazard comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module store_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                push,
  input  store_entry_t                        push_entry,
  input  logic                                pop,
  output store_entry_t                        head,
  output logic [$clog2(DEPTH):0]              count,
  output logic [DEPTH-1:0][15:0]              entry_addr,
  output logic [DEPTH-1:0]                    entry_io_only,
  output logic [DEPTH-1:0]                    entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  store_entry_t [DEPTH-1:0]  mem;
  logic                      do_push;
  logic                      do_pop;

  // A push is refused when full even if a pop happens this cycle, so
  // req_ready never depends on the issue side combinationally.
  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer, occupancy and storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // A slot is live when its distance from rd_ptr is below the occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PW-1:0] rel;
    assign rel              = PW'(i) - rd_ptr;
    assign entry_valid[i]   = ({1'b0, rel} < count);
    assign entry_addr[i]    = mem[i].addr;
    assign entry_io_only[i] = mem[i].io_only;
  end

endmodule
`default_nettype wire

// File: rtl/data_store_writer.sv
`default_nettype none
// ============================================================================
// Module      : data_store_writer
// Description : Posted-write store path of the data space. Queues CPU byte
//               stores, decodes each into the register file, IO file or
//               SRAM and drives a single-cycle write strobe per store, in
//               acceptance order. Flags read-after-write hazards.
//               Optional feature macro: STORE_BOUNDS_CHECK_EN (drop and flag
//               stores beyond the top of SRAM instead of wrapping them).
// Revision    : 1.0 - initial release
// ============================================================================
module data_store_writer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic        req_io_only,
  output logic        reg_we,
  output logic [4:0]  reg_waddr,
  output logic [7:0]  reg_wdata,
  output logic        io_we,
  output logic [5:0]  io_waddr,
  output logic [7:0]  io_wdata,
  output logic        sram_we,
  output logic [10:0] sram_addr,
  output logic [7:0]  sram_wdata,
  input  logic [15:0] rd_addr,
  input  logic        rd_io_only,
  output logic        hazard,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(DEPTH) + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]              state;
  logic [0:0]              next_state;
  logic [CW-1:0]           count;
  store_entry_t            req_entry;
  store_entry_t            head;
  dmem_target_t            head_tgt;
  dmem_target_t            rd_tgt;
  logic [DEPTH-1:0][15:0]  entry_addr;
  logic [DEPTH-1:0]        entry_io_only;
  logic [DEPTH-1:0]        entry_valid;
  logic [DEPTH-1:0]        hit;
  logic                    accept;
  logic                    pop;

  // Last written address/data per destination, held between strobes
  logic [4:0]              reg_waddr_hold;
  logic [7:0]              reg_wdata_hold;
  logic [5:0]              io_waddr_hold;
  logic [7:0]              io_wdata_hold;
  logic [10:0]             sram_addr_hold;
  logic [7:0]              sram_wdata_hold;

  assign req_ready = (count < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign req_entry = '{addr: req_addr, data: req_data, io_only: req_io_only};

  // ISSUE tracks "queue non-empty", so the head is the store being written
  // this cycle and it leaves the queue at the end of the cycle.
  assign pop       = (state == ST_ISSUE);
  assign head_tgt  = dmem_decode(head.addr, head.io_only);

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (accept),
    .push_entry    (req_entry),
    .pop           (pop),
    .head          (head),
    .count         (count),
    .entry_addr    (entry_addr),
    .entry_io_only (entry_io_only),
    .entry_valid   (entry_valid)
  );

  // Issue FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Issue FSM next state: leave ISSUE only when the last entry pops unrefilled
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_ISSUE;
      ST_ISSUE: if ((count == CW'(1)) && !accept) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Issue FSM outputs: one strobe for the head entry, held values otherwise
  always_comb begin
    reg_we     = 1'b0;
    io_we      = 1'b0;
    sram_we    = 1'b0;
    if (state == ST_ISSUE) begin
      case (head_tgt.tgt)
        TGT_REG:  reg_we  = 1'b1;
        TGT_IO:   io_we   = 1'b1;
        TGT_SRAM: sram_we = 1'b1;
        default:  ;
      endcase
    end
    reg_waddr  = reg_we  ? head_tgt.idx[4:0] : reg_waddr_hold;
    reg_wdata  = reg_we  ? head.data         : reg_wdata_hold;
    io_waddr   = io_we   ? head_tgt.idx[5:0] : io_waddr_hold;
    io_wdata   = io_we   ? head.data         : io_wdata_hold;
    sram_addr  = sram_we ? head_tgt.idx      : sram_addr_hold;
    sram_wdata = sram_we ? head.data         : sram_wdata_hold;
  end

  // Capture each destination's address/data as it is written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_waddr_hold  <= '0;
      reg_wdata_hold  <= '0;
      io_waddr_hold   <= '0;
      io_wdata_hold   <= '0;
      sram_addr_hold  <= '0;
      sram_wdata_hold <= '0;
    end else begin
      if (reg_we) begin
        reg_waddr_hold <= reg_waddr;
        reg_wdata_hold <= reg_wdata;
      end
      if (io_we) begin
        io_waddr_hold <= io_waddr;
        io_wdata_hold <= io_wdata;
      end
      if (sram_we) begin
        sram_addr_hold  <= sram_addr;
        sram_wdata_hold <= sram_wdata;
      end
    end
  end

`ifdef STORE_BOUNDS_CHECK_EN
  assign err = (state == ST_ISSUE) && (head_tgt.tgt == TGT_NONE);
`else
  assign err = 1'b0;
`endif

  assign busy = (count != '0) || reg_we || io_we || sram_we;

  // The issuing store is the head slot, so comparing every live slot also
  // covers the store currently on the write strobes.
  assign rd_tgt = dmem_decode(rd_addr, rd_io_only);

  for (genvar i = 0; i < DEPTH; i++) begin : g_hazard
    dmem_target_t e_tgt;
    assign e_tgt  = dmem_decode(entry_addr[i], entry_io_only[i]);
    assign hit[i] = entry_valid[i] && (e_tgt.tgt != TGT_NONE) && (e_tgt == rd_tgt);
  end

  assign hazard = |hit;

endmodule
`default_nettype wire
